// File: rtl/sky130_toolbox_pkg.sv
// Shared helpers for the toolbox synchroniser blocks: minimum chain depth and counter sizing.
package sky130_toolbox_pkg;

  localparam int unsigned SYNC_STAGES_MIN = 2;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dff_glitch_filter.sv
// Per-channel stability filter: q follows sy only after FILTER_CYCLES consecutive differing edges.
// Instantiated by dff_sync_edge only when DFF_SYNC_FILTER_EN is defined.
module dff_glitch_filter
  import sky130_toolbox_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES = 3,
  parameter logic        RESET_BIT     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sy,
  output logic q
);

  localparam int CntW = cnt_w(int'(FILTER_CYCLES));
  localparam logic [CntW-1:0] CntMax = CntW'(FILTER_CYCLES - 1);

  logic [CntW-1:0] cnt_d, cnt_q;
  logic            q_d, q_q;

  always_comb begin
    cnt_d = cnt_q;
    q_d   = q_q;
    if (sy == q_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      q_d   = sy;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      q_q   <= RESET_BIT;
    end else begin
      cnt_q <= cnt_d;
      q_q   <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/dff_sync_edge.sv
// Multi-bit, multi-stage synchroniser with per-bit rise/fall pulses.
// Define DFF_SYNC_FILTER_EN to insert a dff_glitch_filter after each chain.
module dff_sync_edge
  import sky130_toolbox_pkg::*;
#(
  parameter int unsigned       WIDTH         = 1,
  parameter int unsigned       STAGES        = 2,
  parameter logic [WIDTH-1:0]  RESET_VALUE   = '0,
  parameter int unsigned       FILTER_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  if (WIDTH < 1) begin : g_bad_width
    $error("dff_sync_edge: WIDTH must be >= 1");
  end
  if (STAGES < SYNC_STAGES_MIN) begin : g_bad_stages
    $error("dff_sync_edge: STAGES must be >= %0d", SYNC_STAGES_MIN);
  end
  if (FILTER_CYCLES < 1) begin : g_bad_filter
    $error("dff_sync_edge: FILTER_CYCLES must be >= 1");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [STAGES-1:0] s_d, s_q;
    logic              ql_d, ql_q;
    logic              sy;

    // d[i] lands directly in s_q[0]; nothing else observes the first stage.
    always_comb begin
      s_d  = {s_q[STAGES-2:0], d[i]};
      ql_d = q[i];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s_q  <= {STAGES{RESET_VALUE[i]}};
        ql_q <= RESET_VALUE[i];
      end else begin
        s_q  <= s_d;
        ql_q <= ql_d;
      end
    end

    assign sy = s_q[STAGES-1];

`ifdef DFF_SYNC_FILTER_EN
    dff_glitch_filter #(
      .FILTER_CYCLES (FILTER_CYCLES),
      .RESET_BIT     (RESET_VALUE[i])
    ) u_filter (
      .clk (clk),
      .rst (rst),
      .sy  (sy),
      .q   (q[i])
    );
`else
    assign q[i] = sy;
`endif

    assign rise[i] = q[i] & ~ql_q;
    assign fall[i] = ~q[i] & ql_q;
  end

  assign changed = |(rise | fall);

endmodule

// File: tb/tb_dff_sync_edge.sv
// Bench for dff_sync_edge: three configurations against a history-based reference model.
module tb_dff_sync_edge;

`ifdef DFF_SYNC_FILTER_EN
  localparam int FiltExtra = 3;
`else
  localparam int FiltExtra = 0;
`endif
  localparam int FC = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [0:0] d_a, q_a, rise_a, fall_a;
  logic       changed_a;
  logic [3:0] d_b, q_b, rise_b, fall_b;
  logic       changed_b;
  logic [1:0] d_c, q_c, rise_c, fall_c;
  logic       changed_c;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dff_sync_edge #(.WIDTH(1), .STAGES(2), .RESET_VALUE(1'b1), .FILTER_CYCLES(FC)) dut_a (
    .clk(clk), .rst(rst), .d(d_a), .q(q_a), .rise(rise_a), .fall(fall_a), .changed(changed_a)
  );
  dff_sync_edge #(.WIDTH(4), .STAGES(3), .RESET_VALUE(4'h0), .FILTER_CYCLES(FC)) dut_b (
    .clk(clk), .rst(rst), .d(d_b), .q(q_b), .rise(rise_b), .fall(fall_b), .changed(changed_b)
  );
  dff_sync_edge #(.WIDTH(2), .STAGES(2), .RESET_VALUE(2'b00), .FILTER_CYCLES(FC)) dut_c (
    .clk(clk), .rst(rst), .d(d_c), .q(q_c), .rise(rise_c), .fall(fall_c), .changed(changed_c)
  );

  // Reference model: delay line of sampled inputs plus a window of recent synchronised levels.
  logic [7:0][3:0] dh  [3];
  logic [7:0][3:0] syh [3];
  logic [3:0]      mq  [3];
  logic [3:0]      mql [3];

  function automatic logic [3:0] rv_of(int m);
    return (m == 0) ? 4'h1 : 4'h0;
  endfunction

  function automatic int st_of(int m);
    return (m == 1) ? 3 : 2;
  endfunction

  function automatic logic [3:0] din_of(int m);
    case (m)
      0:       return {3'b000, d_a};
      1:       return d_b;
      default: return {2'b00, d_c};
    endcase
  endfunction

`ifdef DFF_SYNC_FILTER_EN
  // A bit flips once the last FC synchronised samples all disagree with it.
  function automatic logic [3:0] filt_next(logic [7:0][3:0] h, logic [3:0] sy, logic [3:0] q);
    logic [3:0] nq;
    logic       all_diff;
    nq = q;
    for (int b = 0; b < 4; b++) begin
      all_diff = (sy[b] != q[b]);
      for (int j = 0; j < FC - 1; j++) begin
        if (h[j][b] == q[b]) all_diff = 1'b0;
      end
      if (all_diff) nq[b] = sy[b];
    end
    return nq;
  endfunction
`endif

  always @(posedge clk or posedge rst) begin
    for (int m = 0; m < 3; m++) begin
      if (rst) begin
        dh[m]  <= {8{rv_of(m)}};
        syh[m] <= {8{rv_of(m)}};
        mq[m]  <= rv_of(m);
        mql[m] <= rv_of(m);
      end else begin
        dh[m]  <= {dh[m][6:0], din_of(m)};
        syh[m] <= {syh[m][6:0], dh[m][st_of(m)-1]};
        mql[m] <= mq[m];
`ifdef DFF_SYNC_FILTER_EN
        mq[m]  <= filt_next(syh[m], dh[m][st_of(m)-1], mq[m]);
`else
        mq[m]  <= dh[m][st_of(m)-2];
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; d_a = 1'b1; d_b = '0; d_c = '0;
    repeat (3) tick();
    tests++;
    if ({q_a, rise_a, fall_a, changed_a} !== 4'b1000) begin
      fails++; $display("FAIL reset_a_held got=%b exp=1000", {q_a, rise_a, fall_a, changed_a});
    end
    tests++;
    if ({q_b, rise_b, fall_b, changed_b} !== 13'h0) begin
      fails++; $display("FAIL reset_b_held got=%h exp=0", {q_b, rise_b, fall_b, changed_b});
    end
    tests++;
    if ({q_c, rise_c, fall_c, changed_c} !== 7'h0) begin
      fails++; $display("FAIL reset_c_held got=%h exp=0", {q_c, rise_c, fall_c, changed_c});
    end
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      tests++;
      if ({q_a, rise_a, fall_a, changed_a} !== 4'b1000) begin
        fails++;
        $display("FAIL reset_a_after cyc=%0d got=%b exp=1000", k, {q_a, rise_a, fall_a, changed_a});
      end
    end
  endtask

  task automatic test_fall_single();
    int fk, nf, nr;
    fk = -1; nf = 0; nr = 0;
    d_a = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (fall_a == 1'b1) begin nf++; fk = k; end
      if (rise_a == 1'b1) nr++;
    end
    tests++;
    if (fk != 2 + FiltExtra) begin fails++; $display("FAIL fall_latency got=%0d exp=%0d", fk, 2 + FiltExtra); end
    tests++;
    if (nf != 1) begin fails++; $display("FAIL fall_count got=%0d exp=1", nf); end
    tests++;
    if (nr != 0) begin fails++; $display("FAIL fall_spurious_rise got=%0d exp=0", nr); end
    tests++;
    if (q_a !== 1'b0) begin fails++; $display("FAIL fall_final_q got=%b exp=0", q_a); end
  endtask

  task automatic test_width4();
    int rk, nch, nf;
    logic [3:0] rv;
    rk = -1; nch = 0; nf = 0; rv = '0;
    d_b = 4'b1010;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (rise_b != 4'b0 && rk < 0) begin rk = k; rv = rise_b; end
      if (changed_b) nch++;
      if (fall_b != 4'b0) nf++;
    end
    tests++;
    if (rk != 3 + FiltExtra) begin fails++; $display("FAIL w4_latency got=%0d exp=%0d", rk, 3 + FiltExtra); end
    tests++;
    if (rv !== 4'b1010) begin fails++; $display("FAIL w4_rise got=%b exp=1010", rv); end
    tests++;
    if (nch != 1) begin fails++; $display("FAIL w4_changed_count got=%0d exp=1", nch); end
    tests++;
    if (nf != 0) begin fails++; $display("FAIL w4_fall_count got=%0d exp=0", nf); end
    tests++;
    if (q_b !== 4'b1010) begin fails++; $display("FAIL w4_final_q got=%b exp=1010", q_b); end
  endtask

  task automatic test_pulse();
    int nr, nf, rk, fk, exp_nr;
    exp_nr = (FiltExtra == 0) ? 1 : 0;
    nr = 0; nf = 0;
    for (int k = 1; k <= 12; k++) begin
      d_a = (k <= 2);
      tick();
      if (rise_a == 1'b1) nr++;
      if (fall_a == 1'b1) nf++;
    end
    tests++;
    if (nr != exp_nr) begin fails++; $display("FAIL pulse2_rise_count got=%0d exp=%0d", nr, exp_nr); end
    tests++;
    if (nf != exp_nr) begin fails++; $display("FAIL pulse2_fall_count got=%0d exp=%0d", nf, exp_nr); end
    rk = -1; fk = -1;
    for (int k = 1; k <= 14; k++) begin
      d_a = (k <= 3);
      tick();
      if (rise_a == 1'b1) rk = k;
      if (fall_a == 1'b1) fk = k;
    end
    tests++;
    if (rk != 2 + FiltExtra) begin fails++; $display("FAIL pulse3_rise got=%0d exp=%0d", rk, 2 + FiltExtra); end
    tests++;
    if (fk != 5 + FiltExtra) begin fails++; $display("FAIL pulse3_fall got=%0d exp=%0d", fk, 5 + FiltExtra); end
  endtask

  task automatic test_toggle();
    int nch, nqc, exp_n;
    logic [1:0] prev;
    exp_n = (FiltExtra == 0) ? 19 : 0;
    d_c = 2'b00;
    repeat (8) tick();
    nch = 0; nqc = 0;
    for (int k = 1; k <= 20; k++) begin
      prev = q_c;
      d_c = 2'(k % 2);
      tick();
      if (changed_c) nch++;
      if (q_c !== prev) nqc++;
    end
    tests++;
    if (nch != exp_n) begin fails++; $display("FAIL toggle_changed got=%0d exp=%0d", nch, exp_n); end
    tests++;
    if (nqc != exp_n) begin fails++; $display("FAIL toggle_q_moves got=%0d exp=%0d", nqc, exp_n); end
  endtask

  task automatic test_reset_mid();
    int fk, nr;
    logic exp_q;
    exp_q = (FiltExtra == 0);
    d_a = 1'b1;
    repeat (4) tick();
    tests++;
    if (q_a !== exp_q) begin fails++; $display("FAIL midrst_before got=%b exp=%b", q_a, exp_q); end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({q_a, rise_a, fall_a} !== 3'b100) begin
      fails++; $display("FAIL midrst_async got=%b exp=100", {q_a, rise_a, fall_a});
    end
    @(negedge clk);
    rst = 1'b0; d_a = 1'b0;
    fk = -1; nr = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (fall_a == 1'b1 && fk < 0) fk = k;
      if (rise_a == 1'b1) nr++;
    end
    tests++;
    if (fk != 2 + FiltExtra) begin fails++; $display("FAIL midrst_fresh_count got=%0d exp=%0d", fk, 2 + FiltExtra); end
    tests++;
    if (nr != 0) begin fails++; $display("FAIL midrst_rise got=%0d exp=0", nr); end
  endtask

  task automatic test_simultaneous();
    int rk, nch;
    logic [1:0] rv, fv;
    d_c = 2'b10;
    repeat (10) tick();
    d_c = 2'b01;
    rk = -1; nch = 0; rv = '0; fv = '0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (rise_c != 2'b00 && rk < 0) begin rk = k; rv = rise_c; fv = fall_c; end
      if (changed_c) nch++;
    end
    tests++;
    if (rk != 2 + FiltExtra) begin fails++; $display("FAIL simul_latency got=%0d exp=%0d", rk, 2 + FiltExtra); end
    tests++;
    if ({rv, fv} !== 4'b0110) begin fails++; $display("FAIL simul_edges got=%b exp=0110", {rv, fv}); end
    tests++;
    if (nch != 1) begin fails++; $display("FAIL simul_changed got=%0d exp=1", nch); end
  endtask

  task automatic test_random();
    logic [3:0] r, f;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 4) == 0) d_a = ~d_a;
      if ($urandom_range(0, 4) == 0) d_b = d_b ^ 4'($urandom_range(1, 15));
      if ($urandom_range(0, 4) == 0) d_c = d_c ^ 2'($urandom_range(1, 3));
      rst = ($urandom_range(0, 79) == 0);
      tick();
      r = mq[0] & ~mql[0]; f = ~mq[0] & mql[0];
      tests++;
      if ({q_a, rise_a, fall_a, changed_a} !== {mq[0][0], r[0], f[0], r[0] | f[0]}) begin
        fails++;
        $display("FAIL rand_a cyc=%0d got=%b exp=%b", k, {q_a, rise_a, fall_a, changed_a},
                 {mq[0][0], r[0], f[0], r[0] | f[0]});
      end
      r = mq[1] & ~mql[1]; f = ~mq[1] & mql[1];
      tests++;
      if ({q_b, rise_b, fall_b, changed_b} !== {mq[1], r, f, |(r | f)}) begin
        fails++;
        $display("FAIL rand_b cyc=%0d got=%b exp=%b", k, {q_b, rise_b, fall_b, changed_b},
                 {mq[1], r, f, |(r | f)});
      end
      r = mq[2] & ~mql[2]; f = ~mq[2] & mql[2];
      tests++;
      if ({q_c, rise_c, fall_c, changed_c} !== {mq[2][1:0], r[1:0], f[1:0], |(r[1:0] | f[1:0])}) begin
        fails++;
        $display("FAIL rand_c cyc=%0d got=%b exp=%b", k, {q_c, rise_c, fall_c, changed_c},
                 {mq[2][1:0], r[1:0], f[1:0], |(r[1:0] | f[1:0])});
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fall_single();
    test_width4();
    test_pulse();
    test_toggle();
    test_reset_mid();
    test_simultaneous();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
